mmio_led_pwm: RTL and testbench

- Memory-mapped LED output peripheral for the Top design; replaces the fixed 8-bit led port with a CPU-addressable block.
- The CPU reaches it through stores and loads to the IO window at BASE_ADDR (0x8000_0000, i.e. R31 = 1<<31).
- Generalised to CHANNELS outputs, each with on/off or PWM brightness and a programmable prescaler.

---
 rtl/mmio_led_pwm_if.sv | 20 ++
 rtl/mmio_led_pwm.sv | 169 ++++++++++++++++
 tb/tb_mmio_led_pwm.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_led_pwm_if.sv
// rtl/mmio_led_pwm_if.sv - CPU load/store bus into the LED PWM peripheral
//
// addr   word address from the CPU
// wdata  store data
// we/re  one-cycle write/read strobes
// rdata  load data, held until the next read
// ready  one-cycle access-complete pulse
interface mmio_led_pwm_if #(
  parameter int ADDR_BITS = 32
);
  logic [ADDR_BITS-1:0] addr;
  logic [31:0]          wdata;
  logic                 we;
  logic                 re;
  logic [31:0]          rdata;
  logic                 ready;

  modport master (output addr, wdata, we, re, input rdata, ready);
  modport slave  (input addr, wdata, we, re, output rdata, ready);
endinterface

// File: rtl/mmio_led_pwm.sv
// rtl/mmio_led_pwm.sv - memory-mapped LED block with direct and PWM brightness
//
// Ports:
//   clk_25mhz  system clock
//   rst_n      asynchronous active-low reset
//   bus        CPU register bus (slave side of mmio_led_pwm_if)
//   led        LED drive, 1 = on
//
// Registers (word index from BASE_ADDR):
//   0 CTRL {MODE, EN}, 1 DIRECT, 2 PRESCALE[15:0], 3+i DUTY[i]
//
// Build option LED_FADE_EN: each channel ramps its compare value one step
// per PWM period toward DUTY[i] instead of switching instantly.
module mmio_led_pwm #(
  parameter int          CHANNELS  = 8,
  parameter int          PWM_BITS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          ADDR_BITS = 32
) (
  input  logic                clk_25mhz,
  input  logic                rst_n,
  mmio_led_pwm_if.slave       bus,
  output logic [CHANNELS-1:0] led
);

  localparam int NREGS = 3 + CHANNELS;
  localparam logic [ADDR_BITS-1:0] BASE = ADDR_BITS'(BASE_ADDR);

  logic                en;
  logic                mode;
  logic [CHANNELS-1:0] direct;
  logic [15:0]         prescale;
  logic [PWM_BITS-1:0] duty [CHANNELS];

  logic [15:0]         pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                wrap;
  logic [CHANNELS-1:0] pwm_cmp;

  logic [ADDR_BITS-1:0] idx;
  logic                 sel;
  logic                 wr;
  logic                 rd;
  logic                 pre_wr;
  logic [31:0]          rd_mux;

  // Addresses below BASE wrap to huge values, so one unsigned compare
  // covers both ends of the window.
  assign idx    = bus.addr - BASE;
  assign sel    = idx < ADDR_BITS'(NREGS);
  assign wr     = bus.we && sel;
  assign rd     = bus.re && !bus.we && sel;
  assign pre_wr = wr && (idx == ADDR_BITS'(2));

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  always_comb begin
    rd_mux = '0;
    if (idx == ADDR_BITS'(0)) begin
      rd_mux[1:0] = {mode, en};
    end else if (idx == ADDR_BITS'(1)) begin
      rd_mux[CHANNELS-1:0] = direct;
    end else if (idx == ADDR_BITS'(2)) begin
      rd_mux[15:0] = prescale;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (idx == ADDR_BITS'(3 + i)) rd_mux[PWM_BITS-1:0] = duty[i];
      end
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      mode     <= 1'b0;
      direct   <= '0;
      prescale <= '0;
      for (int i = 0; i < CHANNELS; i++) duty[i] <= '0;
    end else if (wr) begin
      if (idx == ADDR_BITS'(0)) begin
        en   <= bus.wdata[0];
        mode <= bus.wdata[1];
      end
      if (idx == ADDR_BITS'(1)) direct   <= bus.wdata[CHANNELS-1:0];
      if (idx == ADDR_BITS'(2)) prescale <= bus.wdata[15:0];
      for (int i = 0; i < CHANNELS; i++) begin
        if (idx == ADDR_BITS'(3 + i)) duty[i] <= bus.wdata[PWM_BITS-1:0];
      end
    end
  end

  // A simultaneous write suppresses the read, so rdata keeps its value
  // while ready still pulses once for the write.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= sel && (bus.we || bus.re);
      if (rd) bus.rdata <= rd_mux;
    end
  end

  assign tick = (pre_cnt >= prescale);
  assign wrap = en && tick && (pwm_cnt == '1);

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (pre_wr || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (!en) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

`ifdef LED_FADE_EN
  logic [PWM_BITS-1:0] cur [CHANNELS];

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) cur[i] <= '0;
    end else if (wrap) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cur[i] < duty[i])      cur[i] <= cur[i] + 1'b1;
        else if (cur[i] > duty[i]) cur[i] <= cur[i] - 1'b1;
      end
    end
  end

  always_comb begin
    pwm_cmp = '0;
    for (int i = 0; i < CHANNELS; i++) pwm_cmp[i] = (pwm_cnt < cur[i]);
  end
`else
  logic unused_wrap;
  assign unused_wrap = wrap;

  always_comb begin
    pwm_cmp = '0;
    for (int i = 0; i < CHANNELS; i++) pwm_cmp[i] = (pwm_cnt < duty[i]);
  end
`endif

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else if (!en) begin
      led <= '0;
    end else if (mode) begin
      led <= pwm_cmp;
    end else begin
      led <= direct;
    end
  end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// tb/tb_mmio_led_pwm.sv - scoreboard bench for mmio_led_pwm
module tb_mmio_led_pwm;

  localparam int          CH   = 8;
  localparam int          PB   = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] led;

  always #20 clk = ~clk;

  mmio_led_pwm_if #(.ADDR_BITS(32)) bus ();

  mmio_led_pwm #(
    .CHANNELS (CH),
    .PWM_BITS (PB),
    .BASE_ADDR(BASE),
    .ADDR_BITS(32)
  ) dut (
    .clk_25mhz(clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .led      (led)
  );

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];

  // Reference register file, kept as plain integers.
  bit          m_en, m_mode;
  int          m_direct, m_prescale;
  int          m_duty[CH];
  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_direct = 0; m_prescale = 0; m_rdata = 0;
    for (int i = 0; i < CH; i++) m_duty[i] = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0:       return {30'd0, m_mode, m_en};
      1:       return m_direct;
      2:       return m_prescale;
      default: return m_duty[idx-3];
    endcase
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d);
    case (idx)
      0:       begin m_en = d[0]; m_mode = d[1]; end
      1:       m_direct = d % (1 << CH);
      2:       m_prescale = d % 65536;
      default: m_duty[idx-3] = d % (1 << PB);
    endcase
  endtask

  // Scoreboard monitor: every ready must match the oldest pending access.
  always @(negedge clk) begin
    if (rst_n && bus.ready !== 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_ready: got ready=%b expected no ready", bus.ready);
      end else begin
        check("rdata", bus.rdata, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] idx;
    idx = a - BASE;
    @(negedge clk);
    bus.we = w; bus.re = r; bus.addr = a; bus.wdata = d;
    if (idx < 3 + CH && (w || r)) begin
      if (w) model_write(int'(idx), d);
      else   m_rdata = model_read(int'(idx));
      exp_q.push_back(m_rdata);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.we = 1'b0; bus.re = 1'b0;
    end
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    drive(1'b1, 1'b0, BASE + 32'(idx), d);
  endtask

  task automatic rd(input int idx);
    drive(1'b0, 1'b1, BASE + 32'(idx), 32'h0);
  endtask

  task automatic check_static();
    idle(3);
    check("led_static", led, m_en ? m_direct : 0);
  endtask

  // On-time over one full PWM period is duty*(PRESCALE+1) regardless of phase.
  task automatic pwm_window();
    int cnt[CH];
    int n;
    idle(m_prescale + 6);
    n = 256 * (m_prescale + 1);
    for (int i = 0; i < CH; i++) cnt[i] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) cnt[i] += int'(led[i]);
    end
    for (int i = 0; i < CH; i++) check("pwm_on_time", cnt[i], m_duty[i] * (m_prescale + 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.we = 1'b0; bus.re = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef LED_FADE_EN
  task automatic measure_pulse(output int len);
    int t;
    t = 0; len = 0;
    while (led[0] !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    while (led[0] !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    while (led[0] === 1'b1 && t < 2000) begin @(negedge clk); t++; len++; end
    if (t >= 2000) len = -1;
  endtask
`endif

  initial begin
    #(40 * 60000);
    $display("FAIL timeout: got no finish expected finish within 60000 cycles");
    $fatal(1);
  end

  initial begin
    bit          w, r, ctrl_mode;
    int          k, idx, pre;
    logic [31:0] a, d, ctrl;

    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
    model_reset();
    do_reset();
    check("reset_led", led, 0);
    check("reset_ready", bus.ready, 0);
    check("reset_rdata", bus.rdata, 0);
    rd(0);
    idle(2);

    // Direct mode.
    wr(0, 1);
    wr(1, 32'hFFFF_FFA5);
    idle(3);
    check("direct_led", led, 32'hA5);
    rd(1);
    idle(2);

    // PWM at full rate.
    wr(0, 3); wr(2, 0); wr(3, 64); wr(4, 0); wr(5, 255);
`ifndef LED_FADE_EN
    pwm_window();
`endif

    // Prescaled PWM.
    wr(2, 3); wr(3, 128);
`ifndef LED_FADE_EN
    pwm_window();
`endif

    // Out-of-window addresses and collision.
    wr(3 + CH, 32'h55);
    drive(1'b1, 1'b0, BASE - 1, 32'h77);
    rd(3);
    idle(2);
    wr(0, 1);
    drive(1'b1, 1'b1, BASE + 1, 32'h3C);
    rd(1);
    check_static();

    // Back-to-back accesses.
    wr(1, 32'h0F); rd(1); wr(1, 32'hF0); rd(0); rd(1);
    check_static();

    // Reset lands before the write's clock edge: the access is lost.
    drive(1'b1, 1'b0, BASE + 1, 32'hFF);
    #5;
    do_reset();
    check("mid_reset_ready", bus.ready, 0);
    rd(1);
    idle(2);

`ifdef LED_FADE_EN
    begin
      int len;
      wr(0, 3); wr(2, 0); wr(3, 4);
      idle(2);
      for (int p = 0; p < 6; p++) begin
        measure_pulse(len);
        check("fade_pulse", len, (p < 4) ? p + 1 : 4);
      end
    end
`endif

    // Randomized traffic, then a steady-state output check.
    for (int round = 0; round < 4; round++) begin
      repeat (30) begin
        k = $urandom_range(0, 2);
        w = (k != 1);
        r = (k != 0);
        if ($urandom_range(0, 12) <= 10) begin
          idx = $urandom_range(0, 3 + CH);
          a = BASE + 32'(idx);
        end else begin
          a = $urandom;
        end
        d = $urandom;
        drive(w, r, a, d);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
      pre = $urandom_range(0, 2);
      wr(2, ($urandom & 32'hFFFF_0000) | 32'(pre));
      ctrl = $urandom;
`ifdef LED_FADE_EN
      ctrl[1] = 1'b0;
`endif
      ctrl_mode = ctrl[1];
      wr(0, ctrl);
      if (ctrl[0] && ctrl_mode) pwm_window();
      else check_static();
      rd(0);
      idle(2);
    end

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
